ctrl_pipe_regs: RTL and testbench
=================================

Name: ctrl_pipe_regs

Overview:
- Consumer end of the CONTROL_UNIT output bundle.
- Registers the decoded control word through the ID/EX, EX/MEM and MEM/WB pipeline stages of the PA-RISC datapath.
- Inserts a NOP bubble (all-zero control) on a load-use stall or a branch flush.
- Tracks per-stage valid bits and a saturating bubble counter for debug.

Parameters:
- RD_W, 5, width of the destination-register tag carried with the control word.
- CNT_W, 8, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- SRD  in  2  from CONTROL_UNIT.
- PSW_LE_RE  in  2  from CONTROL_UNIT.
- B  in  1  from CONTROL_UNIT.
- SOH_OP  in  3  from CONTROL_UNIT.
- ALU_OP  in  4  from CONTROL_UNIT.
- RAM_CTRL  in  4  from CONTROL_UNIT.
- L  in  1  from CONTROL_UNIT.
- RF_LE  in  1  from CONTROL_UNIT.
- ID_SR  in  2  from CONTROL_UNIT.
- UB  in  1  from CONTROL_UNIT.
- id_rd  in  RD_W  destination register of the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- stall  in  1  load-use hazard; insert a bubble into EX.
- flush  in  1  taken branch or jump; cancel the instruction in ID.
- ex_SRD, ex_PSW_LE_RE, ex_B, ex_SOH_OP, ex_ALU_OP, ex_RAM_CTRL, ex_L, ex_RF_LE, ex_ID_SR, ex_UB  out  same widths as inputs  ID/EX register contents.
- ex_rd  out  RD_W  ID/EX destination tag.
- ex_valid  out  1  ID/EX holds a real instruction.
- mem_RAM_CTRL  out  4  EX/MEM memory control.
- mem_L  out  1  EX/MEM load select.
- mem_RF_LE  out  1  EX/MEM register-file write enable.
- mem_rd  out  RD_W  EX/MEM destination tag.
- mem_valid  out  1  EX/MEM holds a real instruction.
- wb_RF_LE  out  1  MEM/WB register-file write enable.
- wb_rd  out  RD_W  MEM/WB destination tag.
- wb_valid  out  1  MEM/WB holds a real instruction.
- bubble_cnt  out  CNT_W  number of bubbles inserted.

Behaviour:
- Reset: every output register clears to 0, including bubble_cnt. Reset has priority over all other inputs.
- Per-edge priority for ID/EX: reset > flush > stall > normal.
  - Normal: ID/EX loads all CU inputs plus id_rd; ex_valid takes id_valid.
  - Stall or flush: ID/EX loads the bubble (all fields 0, ex_rd=0, ex_valid=0).
- EX/MEM always advances from ID/EX, regardless of stall or flush:
  - mem_RAM_CTRL takes ex_RAM_CTRL; mem_L, mem_RF_LE, mem_rd take their ex_ values.
  - mem_valid takes ex_valid.
- MEM/WB always advances from EX/MEM: wb_RF_LE, wb_rd, wb_valid take their mem_ values.
- Qualifying: an invalid stage forces its RF_LE and RAM_CTRL outputs to 0, so a stale write-enable can never escape. Because bubbles are all-zero, this is already true at register level. The bench checks it as an invariant.
- Latency: an input sampled at edge k appears on ex_* after edge k, on mem_* after edge k+1, and on wb_* after edge k+2. There is no combinational input-to-output path.
- bubble_cnt:
  - Increments by 1 on every non-reset edge where stall or flush is high.
  - stall and flush together count as one bubble.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- Simultaneous stall and flush: a single bubble is inserted and flush semantics apply.
- Reset asserted mid-operation: all stages are empty on the next edge. In-flight instructions are discarded with no write-back.
- Stage handling never depends on any specific opcode; every CU field is treated as opaque bits.

Test Plan:
- Reset then release, id_valid=1, ALU_OP=4'b0010, RF_LE=1, id_rd=5'd3:
  - Before release, all outputs are 0.
  - 1 edge after release: ex_ALU_OP=0010, ex_rd=3, ex_valid=1.
  - mem_RF_LE=1 one edge later; wb_RF_LE=1, wb_rd=3 two edges later.
- Back-to-back stream id_rd=1,2,3,4 with no hazards: wb_rd shows 1,2,3,4 on consecutive cycles, lagging input by 3 edges.
- Load RAM_CTRL=4'b1001, L=1, id_rd=7, followed by stall for one cycle:
  - EX takes the load, then one bubble (ex_valid=0, ex_RF_LE=0).
  - mem_RAM_CTRL=1001 and mem_L=1 are unaffected.
  - bubble_cnt=1.
- flush and stall together with RF_LE=1 input: ex_* all 0, ex_valid=0, bubble_cnt increments by exactly 1.
- Hold stall high for 300 cycles with CNT_W=8: bubble_cnt stops at 255 and does not wrap to 0.
- Assert reset with three valid instructions in flight: next edge ex_valid=mem_valid=wb_valid=0, wb_RF_LE=0, bubble_cnt=0.

Source files
------------

// File: rtl/ctrl_pipe_regs.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_regs
//
// Takes the decoded control word from CONTROL_UNIT and carries it through the
// ID/EX, EX/MEM and MEM/WB pipeline registers of the PA-RISC datapath. A
// load-use stall or a branch flush swaps the ID/EX load for an all-zero NOP
// bubble. Each stage carries a valid bit. A saturating counter records how
// many bubbles were inserted, for debug.
//
// Ports
//   clk, reset             pipeline clock; synchronous active-high reset
//   SRD .. UB              control fields from CONTROL_UNIT (opaque bits)
//   id_rd, id_valid        destination tag and valid flag of the ID instruction
//   stall, flush           load-use hazard / taken branch: insert a bubble
//   ex_*                   ID/EX register contents (full control word)
//   mem_*                  EX/MEM memory controls, write enable, tag, valid
//   wb_*                   MEM/WB write enable, tag, valid
//   bubble_cnt             saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module ctrl_pipe_regs #(
    parameter int RD_W  = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [1:0]       SRD,
    input  logic [1:0]       PSW_LE_RE,
    input  logic             B,
    input  logic [2:0]       SOH_OP,
    input  logic [3:0]       ALU_OP,
    input  logic [3:0]       RAM_CTRL,
    input  logic             L,
    input  logic             RF_LE,
    input  logic [1:0]       ID_SR,
    input  logic             UB,

    input  logic [RD_W-1:0]  id_rd,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,

    output logic [1:0]       ex_SRD,
    output logic [1:0]       ex_PSW_LE_RE,
    output logic             ex_B,
    output logic [2:0]       ex_SOH_OP,
    output logic [3:0]       ex_ALU_OP,
    output logic [3:0]       ex_RAM_CTRL,
    output logic             ex_L,
    output logic             ex_RF_LE,
    output logic [1:0]       ex_ID_SR,
    output logic             ex_UB,
    output logic [RD_W-1:0]  ex_rd,
    output logic             ex_valid,

    output logic [3:0]       mem_RAM_CTRL,
    output logic             mem_L,
    output logic             mem_RF_LE,
    output logic [RD_W-1:0]  mem_rd,
    output logic             mem_valid,

    output logic             wb_RF_LE,
    output logic [RD_W-1:0]  wb_rd,
    output logic             wb_valid,

    output logic [CNT_W-1:0] bubble_cnt
);

    // The control word is opaque to this block. It is bundled so that a bubble
    // is a single '0 assignment and every field is treated the same way.
    typedef struct packed {
        logic [1:0] srd;
        logic [1:0] psw_le_re;
        logic       b;
        logic [2:0] soh_op;
        logic [3:0] alu_op;
        logic [3:0] ram_ctrl;
        logic       l;
        logic       rf_le;
        logic [1:0] id_sr;
        logic       ub;
    } ctrl_t;

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;

    assign id_ctrl = {SRD, PSW_LE_RE, B, SOH_OP, ALU_OP, RAM_CTRL, L, RF_LE, ID_SR, UB};

    // stall and flush both produce the same all-zero bubble. When both are
    // high, a single bubble is inserted and counted once.
    logic insert_bubble;
    assign insert_bubble = stall | flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // each stage reads its upstream register's pre-edge value and the
            // pipeline shifts by exactly one stage per edge.
            ex_ctrl      <= '0;
            ex_rd        <= '0;
            ex_valid     <= 1'b0;
            mem_RAM_CTRL <= '0;
            mem_L        <= 1'b0;
            mem_RF_LE    <= 1'b0;
            mem_rd       <= '0;
            mem_valid    <= 1'b0;
            wb_RF_LE     <= 1'b0;
            wb_rd        <= '0;
            wb_valid     <= 1'b0;
            bubble_cnt   <= '0;
        end else begin
            // ID/EX: a bubble replaces the incoming instruction.
            if (insert_bubble) begin
                ex_ctrl  <= '0;
                ex_rd    <= '0;
                ex_valid <= 1'b0;
            end else begin
                ex_ctrl  <= id_ctrl;
                ex_rd    <= id_rd;
                ex_valid <= id_valid;
            end

            // EX/MEM and MEM/WB always advance. Hazards only affect the ID/EX
            // entry point, so older instructions keep draining.
            mem_RAM_CTRL <= ex_ctrl.ram_ctrl;
            mem_L        <= ex_ctrl.l;
            mem_RF_LE    <= ex_ctrl.rf_le;
            mem_rd       <= ex_rd;
            mem_valid    <= ex_valid;

            wb_RF_LE     <= mem_RF_LE;
            wb_rd        <= mem_rd;
            wb_valid     <= mem_valid;

            // Saturate at all-ones instead of wrapping.
            if (insert_bubble && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

    // A bubble is all-zero, so an invalid stage already has RF_LE and RAM_CTRL
    // at 0. No extra qualifying gates are needed on the outputs.
    assign ex_SRD       = ex_ctrl.srd;
    assign ex_PSW_LE_RE = ex_ctrl.psw_le_re;
    assign ex_B         = ex_ctrl.b;
    assign ex_SOH_OP    = ex_ctrl.soh_op;
    assign ex_ALU_OP    = ex_ctrl.alu_op;
    assign ex_RAM_CTRL  = ex_ctrl.ram_ctrl;
    assign ex_L         = ex_ctrl.l;
    assign ex_RF_LE     = ex_ctrl.rf_le;
    assign ex_ID_SR     = ex_ctrl.id_sr;
    assign ex_UB        = ex_ctrl.ub;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe_regs
//
// Directed testbench for ctrl_pipe_regs. Each task drives one scenario and
// compares outputs against hand-computed values. Outputs are sampled 1 ns
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe_regs;

    localparam int RD_W  = 5;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic [1:0]       SRD;
    logic [1:0]       PSW_LE_RE;
    logic             B;
    logic [2:0]       SOH_OP;
    logic [3:0]       ALU_OP;
    logic [3:0]       RAM_CTRL;
    logic             L;
    logic             RF_LE;
    logic [1:0]       ID_SR;
    logic             UB;
    logic [RD_W-1:0]  id_rd;
    logic             id_valid;
    logic             stall;
    logic             flush;

    logic [1:0]       ex_SRD;
    logic [1:0]       ex_PSW_LE_RE;
    logic             ex_B;
    logic [2:0]       ex_SOH_OP;
    logic [3:0]       ex_ALU_OP;
    logic [3:0]       ex_RAM_CTRL;
    logic             ex_L;
    logic             ex_RF_LE;
    logic [1:0]       ex_ID_SR;
    logic             ex_UB;
    logic [RD_W-1:0]  ex_rd;
    logic             ex_valid;
    logic [3:0]       mem_RAM_CTRL;
    logic             mem_L;
    logic             mem_RF_LE;
    logic [RD_W-1:0]  mem_rd;
    logic             mem_valid;
    logic             wb_RF_LE;
    logic [RD_W-1:0]  wb_rd;
    logic             wb_valid;
    logic [CNT_W-1:0] bubble_cnt;

    int vectors;
    int miscompares;

    ctrl_pipe_regs #(.RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .SRD          (SRD),
        .PSW_LE_RE    (PSW_LE_RE),
        .B            (B),
        .SOH_OP       (SOH_OP),
        .ALU_OP       (ALU_OP),
        .RAM_CTRL     (RAM_CTRL),
        .L            (L),
        .RF_LE        (RF_LE),
        .ID_SR        (ID_SR),
        .UB           (UB),
        .id_rd        (id_rd),
        .id_valid     (id_valid),
        .stall        (stall),
        .flush        (flush),
        .ex_SRD       (ex_SRD),
        .ex_PSW_LE_RE (ex_PSW_LE_RE),
        .ex_B         (ex_B),
        .ex_SOH_OP    (ex_SOH_OP),
        .ex_ALU_OP    (ex_ALU_OP),
        .ex_RAM_CTRL  (ex_RAM_CTRL),
        .ex_L         (ex_L),
        .ex_RF_LE     (ex_RF_LE),
        .ex_ID_SR     (ex_ID_SR),
        .ex_UB        (ex_UB),
        .ex_rd        (ex_rd),
        .ex_valid     (ex_valid),
        .mem_RAM_CTRL (mem_RAM_CTRL),
        .mem_L        (mem_L),
        .mem_RF_LE    (mem_RF_LE),
        .mem_rd       (mem_rd),
        .mem_valid    (mem_valid),
        .wb_RF_LE     (wb_RF_LE),
        .wb_rd        (wb_rd),
        .wb_valid     (wb_valid),
        .bubble_cnt   (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Complete ID/EX control word, in declaration order (21 bits).
    logic [20:0] ex_word;
    assign ex_word = {ex_SRD, ex_PSW_LE_RE, ex_B, ex_SOH_OP, ex_ALU_OP,
                      ex_RAM_CTRL, ex_L, ex_RF_LE, ex_ID_SR, ex_UB};

    task automatic clear_inputs();
        SRD = '0; PSW_LE_RE = '0; B = 1'b0; SOH_OP = '0; ALU_OP = '0;
        RAM_CTRL = '0; L = 1'b0; RF_LE = 1'b0; ID_SR = '0; UB = 1'b0;
        id_rd = '0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    // Advance one edge, then check that no invalid stage exposes a write
    // enable or memory control.
    task automatic tick();
        @(posedge clk);
        #1;
        vectors++;
        if ((!ex_valid && (ex_RF_LE || ex_RAM_CTRL != 4'd0)) ||
            (!mem_valid && (mem_RF_LE || mem_RAM_CTRL != 4'd0)) ||
            (!wb_valid && wb_RF_LE)) begin
            miscompares++;
            $display("FAIL qualify_invariant t=%0t: ex v=%b le=%b rc=%h mem v=%b le=%b rc=%h wb v=%b le=%b, required no enable in an invalid stage",
                     $time, ex_valid, ex_RF_LE, ex_RAM_CTRL, mem_valid, mem_RF_LE,
                     mem_RAM_CTRL, wb_valid, wb_RF_LE);
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        // Drive non-zero inputs under reset to confirm that reset has priority.
        ALU_OP = 4'hF; RF_LE = 1'b1; id_rd = 5'd9; id_valid = 1'b1; stall = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (ex_word !== 21'd0 || ex_rd !== 5'd0 || ex_valid !== 1'b0 ||
            mem_RAM_CTRL !== 4'd0 || mem_L !== 1'b0 || mem_RF_LE !== 1'b0 ||
            mem_rd !== 5'd0 || mem_valid !== 1'b0 || wb_RF_LE !== 1'b0 ||
            wb_rd !== 5'd0 || wb_valid !== 1'b0 || bubble_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state: ex_word=%h ex_rd=%0d ex_v=%b mem_v=%b wb_v=%b wb_rd=%0d cnt=%0d, required all 0",
                     ex_word, ex_rd, ex_valid, mem_valid, wb_valid, wb_rd, bubble_cnt);
        end
    endtask

    task automatic test_basic_latency();
        clear_inputs();
        reset = 1'b1;
        tick();
        // Release reset with the first instruction already presented.
        reset = 1'b0;
        id_valid = 1'b1; ALU_OP = 4'b0010; RF_LE = 1'b1; id_rd = 5'd3;
        tick();
        clear_inputs();
        vectors++;
        if (ex_ALU_OP !== 4'b0010 || ex_rd !== 5'd3 || ex_valid !== 1'b1 || ex_RF_LE !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_ex: alu=%b rd=%0d v=%b le=%b, required alu=0010 rd=3 v=1 le=1",
                     ex_ALU_OP, ex_rd, ex_valid, ex_RF_LE);
        end
        tick();
        vectors++;
        if (mem_RF_LE !== 1'b1 || mem_rd !== 5'd3 || mem_valid !== 1'b1 || ex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_mem: le=%b rd=%0d v=%b ex_v=%b, required le=1 rd=3 v=1 ex_v=0",
                     mem_RF_LE, mem_rd, mem_valid, ex_valid);
        end
        tick();
        vectors++;
        if (wb_RF_LE !== 1'b1 || wb_rd !== 5'd3 || wb_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_wb: le=%b rd=%0d v=%b, required le=1 rd=3 v=1",
                     wb_RF_LE, wb_rd, wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // id_rd 1..4 on edges 0..3. wb shows rd=t-1 after edge t for t=2..5.
        for (int t = 0; t < 7; t++) begin
            clear_inputs();
            if (t < 4) begin
                id_rd = 5'(t + 1); id_valid = 1'b1; RF_LE = 1'b1;
            end
            tick();
            if (t >= 2 && t <= 5) begin
                vectors++;
                if (wb_rd !== 5'(t - 1) || wb_valid !== 1'b1 || wb_RF_LE !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_wb[%0d]: rd=%0d v=%b le=%b, required rd=%0d v=1 le=1",
                             t, wb_rd, wb_valid, wb_RF_LE, t - 1);
                end
            end
        end
        vectors++;
        if (wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: wb_valid=%b, required 0", wb_valid);
        end
    endtask

    task automatic test_load_stall();
        do_reset();
        RAM_CTRL = 4'b1001; L = 1'b1; RF_LE = 1'b1; id_rd = 5'd7; id_valid = 1'b1;
        tick();
        vectors++;
        if (ex_RAM_CTRL !== 4'b1001 || ex_L !== 1'b1 || ex_rd !== 5'd7 || ex_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL load_ex: rc=%b l=%b rd=%0d v=%b, required rc=1001 l=1 rd=7 v=1",
                     ex_RAM_CTRL, ex_L, ex_rd, ex_valid);
        end
        // Hold the load in ID and stall for one cycle.
        stall = 1'b1;
        tick();
        clear_inputs();
        vectors++;
        if (ex_valid !== 1'b0 || ex_RF_LE !== 1'b0 || ex_word !== 21'd0 || ex_rd !== 5'd0) begin
            miscompares++;
            $display("FAIL stall_bubble: v=%b le=%b word=%h rd=%0d, required all 0",
                     ex_valid, ex_RF_LE, ex_word, ex_rd);
        end
        vectors++;
        if (mem_RAM_CTRL !== 4'b1001 || mem_L !== 1'b1 || mem_rd !== 5'd7 || mem_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_mem: rc=%b l=%b rd=%0d v=%b, required rc=1001 l=1 rd=7 v=1",
                     mem_RAM_CTRL, mem_L, mem_rd, mem_valid);
        end
        vectors++;
        if (bubble_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL stall_cnt: cnt=%0d, required 1", bubble_cnt);
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        SRD = 2'b11; PSW_LE_RE = 2'b11; B = 1'b1; SOH_OP = 3'b111; ALU_OP = 4'hF;
        RAM_CTRL = 4'hF; L = 1'b1; RF_LE = 1'b1; ID_SR = 2'b11; UB = 1'b1;
        id_rd = 5'd31; id_valid = 1'b1;
        stall = 1'b1; flush = 1'b1;
        tick();
        vectors++;
        if (ex_word !== 21'd0 || ex_rd !== 5'd0 || ex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_stall_ex: word=%h rd=%0d v=%b, required all 0",
                     ex_word, ex_rd, ex_valid);
        end
        vectors++;
        if (bubble_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL flush_stall_cnt: cnt=%0d, required 1", bubble_cnt);
        end
        // Flush alone also inserts a bubble and counts.
        stall = 1'b0;
        tick();
        vectors++;
        if (ex_valid !== 1'b0 || ex_word !== 21'd0 || bubble_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL flush_only: v=%b word=%h cnt=%0d, required v=0 word=0 cnt=2",
                     ex_valid, ex_word, bubble_cnt);
        end
        // With the hazards dropped, the held instruction enters EX and the count holds.
        flush = 1'b0;
        tick();
        clear_inputs();
        vectors++;
        if (ex_word !== 21'h1FFFFF || ex_rd !== 5'd31 || ex_valid !== 1'b1 || bubble_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL flush_resume: word=%h rd=%0d v=%b cnt=%0d, required word=1fffff rd=31 v=1 cnt=2",
                     ex_word, ex_rd, ex_valid, bubble_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        stall = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254 || i == 255 || i == 256) begin
                vectors++;
                if (bubble_cnt !== ((i >= 255) ? 8'd255 : 8'(i))) begin
                    miscompares++;
                    $display("FAIL sat_cnt[%0d]: cnt=%0d, required %0d",
                             i, bubble_cnt, (i >= 255) ? 255 : i);
                end
            end
        end
        clear_inputs();
        vectors++;
        if (bubble_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_hold: cnt=%0d, required 255", bubble_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        flush = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            id_valid = 1'b1; RF_LE = 1'b1; RAM_CTRL = 4'b0101; id_rd = 5'(10 + i);
            tick();
        end
        clear_inputs();
        vectors++;
        if (ex_valid !== 1'b1 || mem_valid !== 1'b1 || wb_valid !== 1'b1 || bubble_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL midflight_pre: ex_v=%b mem_v=%b wb_v=%b cnt=%0d, required 1 1 1 cnt=1",
                     ex_valid, mem_valid, wb_valid, bubble_cnt);
        end
        reset = 1'b1;
        id_valid = 1'b1; RF_LE = 1'b1; id_rd = 5'd20;
        tick();
        reset = 1'b0;
        clear_inputs();
        vectors++;
        if (ex_valid !== 1'b0 || mem_valid !== 1'b0 || wb_valid !== 1'b0 ||
            wb_RF_LE !== 1'b0 || mem_RF_LE !== 1'b0 || ex_RF_LE !== 1'b0 ||
            mem_RAM_CTRL !== 4'd0 || bubble_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL midflight_reset: ex_v=%b mem_v=%b wb_v=%b wb_le=%b mem_rc=%h cnt=%0d, required all 0",
                     ex_valid, mem_valid, wb_valid, wb_RF_LE, mem_RAM_CTRL, bubble_cnt);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        clear_inputs();

        test_reset();
        test_basic_latency();
        test_back_to_back();
        test_load_stall();
        test_flush_stall();
        test_saturation();
        test_reset_midflight();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
